// File: rtl/dft_sqrt_sched_if.sv
// Requester and sqrt-core signal bundle for the shared sqrt scheduler.
// slave = scheduler side, master = requester/core side.
interface dft_sqrt_sched_if #(
   parameter int DATA_W = 32,
   parameter int N_REQ  = 4
);
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [DATA_W/2-1:0]     rsp_result;
   logic [N_REQ-1:0]        rsp_valid;
   logic                    rsp_ready;
   logic [DATA_W-1:0]       sqrt_data;
   logic                    sqrt_valid;
   logic [DATA_W/2-1:0]     sqrt_result;
   logic                    sqrt_done;

   modport slave (
      input  req_data, req_valid, rsp_ready, sqrt_result, sqrt_done,
      output req_ready, rsp_result, rsp_valid, sqrt_data, sqrt_valid
   );

   modport master (
      output req_data, req_valid, rsp_ready, sqrt_result, sqrt_done,
      input  req_ready, rsp_result, rsp_valid, sqrt_data, sqrt_valid
   );
endinterface

// File: rtl/dft_sqrt_sched.sv
// Round-robin scheduler sharing one sqrt core among N_REQ requesters:
// accept, issue, wait (with timeout), respond.
module dft_sqrt_sched #(
   parameter int DATA_W  = 32,
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            rst,
   dft_sqrt_sched_if.slave bus,
   output logic            busy,
   output logic            timeout_err
);
   localparam int RES_W = DATA_W / 2;
   localparam int GW    = $clog2(N_REQ);
   localparam int CW    = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state;
   logic [GW-1:0]     last_grant;
   logic [GW-1:0]     grant;
   logic [GW-1:0]     pick;
   logic              pick_vld;
   logic [GW:0]       idx;
   logic [CW-1:0]     wait_cnt;
   logic [DATA_W-1:0] radicand;
   logic [RES_W-1:0]  result;
   logic [N_REQ-1:0]  rsp_vld;
   logic              sqrt_vld;
   logic [N_REQ-1:0]  grant_oh;

   // Rotating priority: scan upward from last_grant+1, wrapping at N_REQ.
   always_comb begin
      pick     = last_grant;
      pick_vld = 1'b0;
      idx      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = {1'b0, last_grant} + (GW+1)'(k);
         if (idx >= (GW+1)'(N_REQ)) idx = idx - (GW+1)'(N_REQ);
         if (!pick_vld && bus.req_valid[idx[GW-1:0]]) begin
            pick_vld = 1'b1;
            pick     = idx[GW-1:0];
         end
      end
   end

   assign grant_oh       = N_REQ'(1) << grant;
   assign bus.req_ready  = (state == IDLE && !rst && pick_vld) ? (N_REQ'(1) << pick) : '0;
   assign bus.rsp_valid  = rsp_vld;
   assign bus.rsp_result = result;
   assign bus.sqrt_data  = radicand;
   assign bus.sqrt_valid = sqrt_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= GW'(N_REQ - 1);
         grant       <= '0;
         wait_cnt    <= '0;
         radicand    <= '0;
         result      <= '0;
         rsp_vld     <= '0;
         sqrt_vld    <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  grant    <= pick;
                  radicand <= bus.req_data[int'(pick)*DATA_W +: DATA_W];
                  sqrt_vld <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               sqrt_vld <= 1'b0;
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               wait_cnt <= wait_cnt + 1'b1;
               // A done arriving on the last allowed cycle still counts as success.
               if (bus.sqrt_done) begin
                  result  <= bus.sqrt_result;
                  rsp_vld <= grant_oh;
                  state   <= RESP;
               end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                  result      <= '0;
                  timeout_err <= 1'b1;
                  rsp_vld     <= grant_oh;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_vld    <= '0;
                  last_grant <= grant;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/dft_sqrt_sched.md
DFT_SQRT_SCHED -- requirements
Module: dft_sqrt_sched

Interface
REQ-001 Parameter DATA_W, 32, radicand width (even, >=4); result width is DATA_W/2.
REQ-002 Parameter N_REQ, 4, number of requesters (2..8).
REQ-003 Parameter TIMEOUT, 64, maximum cycles spent in WAIT before abort (>=2).
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_data  in  N_REQ*DATA_W  radicands; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-007 req_valid  in  N_REQ  per-requester request valid.
REQ-008 req_ready  out  N_REQ  per-requester accept, combinational, at most one bit set.
REQ-009 rsp_result  out  DATA_W/2  result of the current response.
REQ-010 rsp_valid  out  N_REQ  one-hot response valid, addressed to the granted requester.
REQ-011 rsp_ready  in  1  response accept from the addressed requester.
REQ-012 sqrt_data  out  DATA_W  radicand to the shared sqrt core.
REQ-013 sqrt_valid  out  1  one-cycle start pulse to the sqrt core.
REQ-014 sqrt_result  in  DATA_W/2  sqrt core result, sampled only on sqrt_done.
REQ-015 sqrt_done  in  1  sqrt core completion pulse.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 timeout_err  out  1  sticky flag: a WAIT phase has timed out.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one active per cycle.
REQ-019 IDLE: if any req_valid is set, select g = first set bit searching upward (with wrap) from last_grant+1; drive req_ready[g]=1 that cycle only; the transfer completes in that cycle; capture req_data[g] and g; next state ISSUE.
REQ-020 IDLE with no req_valid: req_ready all 0; remain in IDLE.
REQ-021 ISSUE: sqrt_valid=1 for exactly one cycle; sqrt_data = captured radicand; clear the wait counter; next state WAIT.
REQ-022 sqrt_data holds the captured radicand from ISSUE until the next capture.
REQ-023 WAIT: increment the wait counter each cycle; on sqrt_done, register sqrt_result into rsp_result and go to RESP.
REQ-024 WAIT timeout: if the counter reaches TIMEOUT-1 without sqrt_done, set rsp_result = 0, set timeout_err, go to RESP; sqrt_done in that same cycle wins (normal completion, no error).
REQ-025 RESP: rsp_valid[g]=1 and rsp_result stable until rsp_ready=1; on the accepting cycle, update last_grant <= g and go to IDLE.
REQ-026 sqrt_done outside WAIT is ignored; no state change.
REQ-027 req_valid changes outside IDLE are ignored; requests are never accepted outside IDLE.
REQ-028 Fairness: a requester holding req_valid continuously is granted within N_REQ grants.
REQ-029 Latency with rsp_ready held at 1 and a core latency of L cycles (sqrt_valid to sqrt_done): rsp_valid rises L+2 cycles after the accept cycle; the next accept occurs no earlier than L+3 cycles after the previous accept.
REQ-030 No arithmetic is performed on the data; the result width is exactly DATA_W/2 and is passed unmodified.

Reset
REQ-031 With rst=1 at a clock edge: state IDLE, last_grant = N_REQ-1 (requester 0 has highest priority), wait counter 0, captured radicand 0, rsp_result 0, timeout_err 0.
REQ-032 During and after reset: req_ready, rsp_valid, sqrt_valid and busy are 0 until the next accept.
REQ-033 Reset asserted in any state, including mid-WAIT, aborts the transaction with no response; a later stray sqrt_done is ignored per REQ-026.
REQ-034 timeout_err clears only on reset.

Verification
REQ-035 Single request: req 0 with 1000000 and core model latency L=17 -> one sqrt_valid pulse with sqrt_data=1000000; rsp_valid=4'b0001 and rsp_result=1000 appear 19 cycles after the accept.
REQ-036 Round robin: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; exactly one req_ready bit per accept.
REQ-037 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid and rsp_result (65535 for input 0xFFFFFFFF) held stable; no new accept or sqrt_valid until the accepting cycle.
REQ-038 Timeout: core model never returns done -> after 64 WAIT cycles, rsp_result=0 and timeout_err=1; later requests are still served, and timeout_err stays 1.
REQ-039 Done and timeout coincide: sqrt_done on the 64th WAIT cycle with input 15 -> rsp_result=3 and timeout_err stays 0.
REQ-040 Reset mid-WAIT, followed by a stray sqrt_done -> no rsp_valid; the next request goes to requester 0 first when all request together.
